// File: rtl/sprite_layer_mapper.sv
// sprite_layer_mapper: 2-stage pipelined sprite ROM address generator with per-channel double-buffered config
// Ports: clk, rst (sync, active-high); frame_start copies pending config to active;
// cfg_we/cfg_sel/cfg_* write one channel's pending config; in_valid/hdata/vdata pixel in;
// out_valid/out_hit/out_id/out_addr registered result, 2 cycles after the pixel.
module sprite_layer_mapper #(
    parameter int HWIDTH = 10,
    parameter int VWIDTH = 10,
    parameter int AWIDTH = 10,
    parameter int NSPR = 4,
    parameter int HSIZE = 32,
    parameter int VSIZE = 32,
    parameter int SWIDTH = 2,
    localparam int IW = NSPR > 1 ? $clog2(NSPR) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_sel,
    input  logic              cfg_en,
    input  logic [HWIDTH-1:0] cfg_hoff,
    input  logic [VWIDTH-1:0] cfg_voff,
    input  logic              cfg_hflip,
    input  logic              cfg_vflip,
    input  logic [SWIDTH-1:0] cfg_shift,
    input  logic              in_valid,
    input  logic [HWIDTH-1:0] hdata,
    input  logic [VWIDTH-1:0] vdata,
    output logic              out_valid,
    output logic              out_hit,
    output logic [IW-1:0]     out_id,
    output logic [AWIDTH-1:0] out_addr
);
    localparam int HB = $clog2(HSIZE);
    localparam int VB = $clog2(VSIZE);
    logic [NSPR-1:0]   pend_en, pend_hflip, pend_vflip, act_en, act_hflip, act_vflip;
    logic [HWIDTH-1:0] pend_hoff [NSPR];
    logic [HWIDTH-1:0] act_hoff [NSPR];
    logic [VWIDTH-1:0] pend_voff [NSPR];
    logic [VWIDTH-1:0] act_voff [NSPR];
    logic [SWIDTH-1:0] pend_shift [NSPR];
    logic [SWIDTH-1:0] act_shift [NSPR];
    logic [HWIDTH-1:0] lx [NSPR];
    logic [VWIDTH-1:0] ly [NSPR];
    logic [HB-1:0]     tx [NSPR];
    logic [VB-1:0]     ty [NSPR];
    logic [NSPR-1:0]   hit_d, hit1;
    logic [AWIDTH-1:0] addr_d [NSPR];
    logic [AWIDTH-1:0] addr1 [NSPR];
    logic              v1, win_hit;
    logic [IW-1:0]     win_id;
    logic [AWIDTH-1:0] win_addr;

    // Active bank takes the pre-write pending value when a write coincides with frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_en <= '0;
            pend_hflip <= '0;
            pend_vflip <= '0;
            pend_hoff <= '{default: '0};
            pend_voff <= '{default: '0};
            pend_shift <= '{default: '0};
            act_en <= '0;
            act_hflip <= '0;
            act_vflip <= '0;
            act_hoff <= '{default: '0};
            act_voff <= '{default: '0};
            act_shift <= '{default: '0};
        end else begin
            if (frame_start) begin
                act_en <= pend_en;
                act_hflip <= pend_hflip;
                act_vflip <= pend_vflip;
                act_hoff <= pend_hoff;
                act_voff <= pend_voff;
                act_shift <= pend_shift;
            end
            if (cfg_we && 32'(cfg_sel) < NSPR) begin
                pend_en[cfg_sel] <= cfg_en;
                pend_hflip[cfg_sel] <= cfg_hflip;
                pend_vflip[cfg_sel] <= cfg_vflip;
                pend_hoff[cfg_sel] <= cfg_hoff;
                pend_voff[cfg_sel] <= cfg_voff;
                pend_shift[cfg_sel] <= cfg_shift;
            end
        end
    end

    // Negative offsets wrap to large unsigned values, so one unsigned compare covers both edges.
    // With tx < HSIZE, HSIZE-1-tx is a bitwise inversion.
    always_comb begin
        for (int c = 0; c < NSPR; c++) begin
            lx[c] = hdata - act_hoff[c];
            ly[c] = vdata - act_voff[c];
            tx[c] = HB'(lx[c] >> act_shift[c]) ^ {HB{act_hflip[c]}};
            ty[c] = VB'(ly[c] >> act_shift[c]) ^ {VB{act_vflip[c]}};
            hit_d[c] = act_en[c] && ({1'b0, lx[c]} < ((HWIDTH+1)'(HSIZE) << act_shift[c]))
                                 && ({1'b0, ly[c]} < ((VWIDTH+1)'(VSIZE) << act_shift[c]));
            addr_d[c] = AWIDTH'({ty[c], tx[c]});
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_id = '0;
        win_addr = '0;
        for (int c = NSPR - 1; c >= 0; c--) begin
            if (hit1[c]) begin
                win_hit = 1'b1;
                win_id = IW'(c);
                win_addr = addr1[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            hit1 <= '0;
            addr1 <= '{default: '0};
            out_valid <= 1'b0;
            out_hit <= 1'b0;
            out_id <= '0;
            out_addr <= '0;
        end else begin
            v1 <= in_valid;
            hit1 <= hit_d;
            addr1 <= addr_d;
            out_valid <= v1;
            out_hit <= win_hit;
            out_id <= win_id;
            out_addr <= win_addr;
        end
    end
endmodule
